// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Sequences the ALU_Reg datapath (register file, ALU, tri-state bus) to fill
//   a ring of registers with a recurrence: Fibonacci, arithmetic step or
//   doubling. A run is kicked off by a start pulse and ends with a one-cycle
//   done pulse. A run aborts early if a generated term carries out of the ALU.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous, active-high reset
//   i_start      begin a run (only honoured while idle)
//   i_mode       0=FIB, 1=ARITH, 2=DOUBLE, 3=FIB
//   i_seed0      term 0 value
//   i_seed1      term 1 (FIB) / step (ARITH) / unused (DOUBLE)
//   i_count      total number of terms, seeds included
//   i_carry_in   ALU carry flag, valid the cycle after an ALU write
//   o_alu_op     ALU opcode
//   o_mux_a      A-operand register index
//   o_mux_b      B-operand register index
//   o_imm        immediate operand
//   o_imm_sel    1 = B operand taken from o_imm
//   o_reg_en     one-hot register write enable
//   o_buff_en    ALU tri-state drive enable
//   o_busy       run in progress
//   o_done       one-cycle completion pulse
//   o_ovf        sticky: last run aborted on carry
//   o_last_idx   index of the last register written
//
// state | meaning
// IDLE  | waiting for start; inputs latched when it arrives
// LOAD0 | MOVI seed0 into r0
// LOAD1 | second seed: MOVI seed1 (FIB) or r0+step / r0+r0 into r1
// STEP  | write the next term into the ring slot pointed to by r_widx
// CHK   | no write; inspect carry of the previous STEP, decide DONE/STEP
// DONE  | one-cycle done pulse, then back to IDLE

module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int SEL_W = 5,
    parameter int OP_W  = 8,
    parameter int CNT_W = 8,
    parameter logic [OP_W-1:0] OP_ADD  = 8'h05,
    parameter logic [OP_W-1:0] OP_MOVI = 8'h0D
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_seed0,
    input  logic [WIDTH-1:0] i_seed1,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_carry_in,
    output logic [OP_W-1:0]  o_alu_op,
    output logic [SEL_W-1:0] o_mux_a,
    output logic [SEL_W-1:0] o_mux_b,
    output logic [WIDTH-1:0] o_imm,
    output logic             o_imm_sel,
    output logic [NREGS-1:0] o_reg_en,
    output logic             o_buff_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic [SEL_W-1:0] o_last_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_STEP  = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0]       M_ARITH  = 2'd1;
    localparam logic [1:0]       M_DOUBLE = 2'd2;
    localparam logic [SEL_W-1:0] IDX_TOP  = SEL_W'(NREGS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_seed0;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] r_left;     // terms still to be written
    logic [SEL_W-1:0] r_widx;     // ring slot of the next write
    logic             r_ovf;
    logic [SEL_W-1:0] r_last_idx;

    logic [SEL_W-1:0] w_idx_m1;
    logic [SEL_W-1:0] w_idx_m2;
    logic [SEL_W-1:0] w_idx_p1;
    logic [NREGS-1:0] w_onehot;
    logic             w_wr;
    logic             w_ovf_set;
    logic             w_accept;
    logic [OP_W-1:0]  w_alu_op;
    logic [SEL_W-1:0] w_mux_a;
    logic [SEL_W-1:0] w_mux_b;
    logic [WIDTH-1:0] w_imm;
    logic             w_imm_sel;
    logic             w_busy;
    logic             w_done;

    // Ring arithmetic: operands wrap downward, the write pointer wraps upward.
    assign w_idx_m1 = (r_widx == '0)   ? IDX_TOP : r_widx - 1'b1;
    assign w_idx_m2 = (w_idx_m1 == '0) ? IDX_TOP : w_idx_m1 - 1'b1;
    assign w_idx_p1 = (r_widx == IDX_TOP) ? '0 : r_widx + 1'b1;
    assign w_onehot = {{(NREGS-1){1'b0}}, 1'b1} << r_widx;
    assign w_accept = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = '0;
        w_mux_a     = '0;
        w_mux_b     = '0;
        w_imm       = '0;
        w_imm_sel   = 1'b0;
        w_wr        = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = (i_count == '0) ? S_DONE : S_LOAD0;
                end
            end
            S_LOAD0: begin
                w_wr        = 1'b1;
                w_alu_op    = OP_MOVI;
                w_imm       = r_seed0;
                w_imm_sel   = 1'b1;
                w_state_nxt = (r_left == CNT_W'(1)) ? S_DONE : S_LOAD1;
            end
            S_LOAD1: begin
                w_wr = 1'b1;
                if (r_mode == M_ARITH) begin
                    w_alu_op  = OP_ADD;
                    w_imm     = r_step;
                    w_imm_sel = 1'b1;
                end else if (r_mode == M_DOUBLE) begin
                    w_alu_op = OP_ADD;
                end else begin
                    w_alu_op  = OP_MOVI;
                    w_imm     = r_step;
                    w_imm_sel = 1'b1;
                end
                w_state_nxt = (r_left == CNT_W'(1)) ? S_DONE : S_STEP;
            end
            S_STEP: begin
                w_wr     = 1'b1;
                w_alu_op = OP_ADD;
                w_mux_a  = w_idx_m1;
                if (r_mode == M_ARITH) begin
                    w_imm     = r_step;
                    w_imm_sel = 1'b1;
                end else if (r_mode == M_DOUBLE) begin
                    w_mux_b = w_idx_m1;
                end else begin
                    w_mux_b = w_idx_m2;
                end
                w_state_nxt = S_CHK;
            end
            S_CHK: begin
                if (i_carry_in) begin
                    w_ovf_set   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_left == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_STEP;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mode     <= '0;
            r_seed0    <= '0;
            r_step     <= '0;
            r_left     <= '0;
            r_widx     <= '0;
            r_ovf      <= 1'b0;
            r_last_idx <= '0;
        end else if (w_accept) begin
            r_mode  <= i_mode;
            r_seed0 <= i_seed0;
            r_step  <= i_seed1;
            r_left  <= i_count;
            r_widx  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_left     <= r_left - 1'b1;
                r_last_idx <= r_widx;
                r_widx     <= w_idx_p1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_alu_op   = w_alu_op;
    assign o_mux_a    = w_mux_a;
    assign o_mux_b    = w_mux_b;
    assign o_imm      = w_imm;
    assign o_imm_sel  = w_imm_sel;
    assign o_reg_en   = w_wr ? w_onehot : '0;
    assign o_buff_en  = w_wr;
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_ovf      = r_ovf;
    assign o_last_idx = r_last_idx;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Drives alu_seq_ctrl against a small ALU_Reg stand-in (register ring, adder,
//   carry flag) and compares every cycle of a run with a term-level model of
//   the recurrence and its cycle schedule.

module tb_alu_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int SEL_W = 5;
    localparam int OP_W  = 8;
    localparam int CNT_W = 8;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_MOVI = 8'h0D;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             env_init = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = '0;
    logic [WIDTH-1:0] seed0 = '0;
    logic [WIDTH-1:0] seed1 = '0;
    logic [CNT_W-1:0] count = '0;
    logic             carry_q;
    logic [OP_W-1:0]  o_alu_op;
    logic [SEL_W-1:0] o_mux_a;
    logic [SEL_W-1:0] o_mux_b;
    logic [WIDTH-1:0] o_imm;
    logic             o_imm_sel;
    logic [NREGS-1:0] o_reg_en;
    logic             o_buff_en;
    logic             o_busy;
    logic             o_done;
    logic             o_ovf;
    logic [SEL_W-1:0] o_last_idx;

    always #5 clk = ~clk;

    alu_seq_ctrl #(
        .WIDTH(WIDTH), .NREGS(NREGS), .SEL_W(SEL_W), .OP_W(OP_W), .CNT_W(CNT_W),
        .OP_ADD(OP_ADD), .OP_MOVI(OP_MOVI)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
        .i_seed0(seed0), .i_seed1(seed1), .i_count(count), .i_carry_in(carry_q),
        .o_alu_op(o_alu_op), .o_mux_a(o_mux_a), .o_mux_b(o_mux_b), .o_imm(o_imm),
        .o_imm_sel(o_imm_sel), .o_reg_en(o_reg_en), .o_buff_en(o_buff_en),
        .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf), .o_last_idx(o_last_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- datapath stand-in ----------------
    logic [15:0] env_regs [NREGS];
    logic [16:0] alu_res;
    logic [15:0] opa, opb;

    always_comb begin
        opa = (o_mux_a < SEL_W'(NREGS)) ? env_regs[o_mux_a[3:0]] : 16'hBAD0;
        opb = o_imm_sel ? o_imm :
              ((o_mux_b < SEL_W'(NREGS)) ? env_regs[o_mux_b[3:0]] : 16'hBAD1);
        if (o_alu_op == OP_MOVI)     alu_res = {1'b0, o_imm};
        else if (o_alu_op == OP_ADD) alu_res = {1'b0, opa} + {1'b0, opb};
        else                         alu_res = 17'h1FFFF;
    end

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < NREGS; i++) env_regs[i] <= '0;
            carry_q <= 1'b0;
        end else if (rst) begin
            carry_q <= 1'b0;
        end else if (o_buff_en && (o_reg_en != '0)) begin
            for (int i = 0; i < NREGS; i++)
                if (o_reg_en[i]) env_regs[i] <= alu_res[15:0];
            carry_q <= alu_res[16];
        end
    end

    // ---------------- reference model ----------------
    int          m_t   [256];
    int          m_kat [520];  // cycle after start -> term index written (-1 none)
    int          m_nw, m_done, m_last;
    bit          m_abort;
    int          prev_last = 0;
    logic [15:0] mdl_regs [NREGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Terms are computed with full precision; the ring holds the low 16 bits.
    // Term 0 is written on cycle 0, term 1 on cycle 1, term k>=2 on cycle 2k-2
    // (each STEP followed by a CHK). A carry out of term k>=2 ends the run.
    task automatic build_model(input int md, input int s0, input int s1, input int cnt);
        longint v;
        for (int i = 0; i < 520; i++) m_kat[i] = -1;
        m_abort = 1'b0;
        m_nw    = 0;
        for (int k = 0; k < cnt; k++) begin
            if (k == 0)       v = s0;
            else if (k == 1)  v = (md == 1) ? longint'(s0 + s1) : (md == 2) ? longint'(2 * s0) : longint'(s1);
            else if (md == 1) v = longint'(m_t[k-1] + s1);
            else if (md == 2) v = longint'(2 * m_t[k-1]);
            else              v = longint'(m_t[k-1] + m_t[k-2]);
            m_t[k] = int'(v & 64'hFFFF);
            m_nw   = k + 1;
            m_kat[(k < 2) ? k : 2*k - 2] = k;
            if (k >= 2 && v > 65535) begin
                m_abort = 1'b1;
                break;
            end
        end
        m_done = (cnt == 0) ? 0 : (cnt == 1) ? 1 : 2 * (m_nw - 1);
        m_last = (m_nw == 0) ? prev_last : (m_nw - 1) % NREGS;
    endtask

    task automatic apply_terms(input int n);
        for (int k = 0; k < n; k++) mdl_regs[k % NREGS] = m_t[k][15:0];
    endtask

    // ---------------- cycle-by-cycle compare ----------------
    bit mon_on  = 1'b0;
    int mon_cyc = 0;

    always @(negedge clk) begin : mon
        int k;
        if (mon_on) begin
            k = m_kat[mon_cyc];
            if (mon_cyc == m_done) begin
                check("done_pulse", 32'(o_done), 32'd1);
                check("done_busy", 32'(o_busy), 32'd1);
                check("done_no_write", {15'd0, o_buff_en, o_reg_en}, 32'd0);
                check("ovf", 32'(o_ovf), 32'(m_abort));
                check("last_idx", 32'(o_last_idx), 32'(m_last));
                mon_on = 1'b0;
            end else begin
                check("busy", 32'(o_busy), 32'd1);
                check("early_done", 32'(o_done), 32'd0);
                if (mon_cyc == 0) check("ovf_cleared", 32'(o_ovf), 32'd0);
                if (k >= 0) begin
                    check("reg_en", 32'(o_reg_en), 32'd1 << (k % NREGS));
                    check("buff_en", 32'(o_buff_en), 32'd1);
                    check("term_value", 32'(alu_res[15:0]), 32'(m_t[k]));
                end else begin
                    check("chk_reg_en", 32'(o_reg_en), 32'd0);
                    check("chk_buff_en", 32'(o_buff_en), 32'd0);
                    check("chk_alu_op", 32'(o_alu_op), 32'd0);
                    check("chk_imm_sel", 32'(o_imm_sel), 32'd0);
                end
            end
            mon_cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int md, input int s0, input int s1, input int cnt, input bit poke);
        build_model(md, s0, s1, cnt);
        @(negedge clk);
        mode  = 2'(md);
        seed0 = 16'(s0);
        seed1 = 16'(s1);
        count = 8'(cnt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mon_cyc = 0;
        mon_on  = 1'b1;
        // Inputs are latched at start; scribble over them for the rest of the run.
        mode  = 2'($urandom);
        seed0 = 16'($urandom);
        seed1 = 16'($urandom);
        count = 8'($urandom);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 600 && mon_on; i++) @(posedge clk);
        if (mon_on) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: got no done, expected done at cycle %0d", m_done);
            mon_on = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);
        apply_terms(m_nw);
        prev_last = m_last;
        for (int i = 0; i < NREGS; i++) check("reg_file", 32'(env_regs[i]), 32'(mdl_regs[i]));
    endtask

    int fib_exp  [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int ari_exp  [5]  = '{100, 107, 114, 121, 128};
    int dbl_exp  [4]  = '{3, 6, 12, 24};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) mdl_regs[i] = '0;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_reg_en", 32'(o_reg_en), 32'd0);
        check("rst_buff_en", 32'(o_buff_en), 32'd0);
        check("rst_alu_op", 32'(o_alu_op), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_last_idx", 32'(o_last_idx), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        env_init = 1'b0;

        run(0, 0, 1, 10, 1'b0);
        for (int i = 0; i < 10; i++) check("fib10_reg", 32'(env_regs[i]), 32'(fib_exp[i]));
        check("fib10_model_t9", 32'(m_t[9]), 32'd34);
        check("fib10_last_idx", 32'(o_last_idx), 32'd9);

        run(0, 0, 1, 25, 1'b1);
        check("fib25_r8", 32'(env_regs[8]), 32'd46368);
        check("fib25_r7", 32'(env_regs[7]), 32'd28657);
        check("fib25_last_idx", 32'(o_last_idx), 32'd8);
        check("fib25_ovf", 32'(o_ovf), 32'd0);

        // F25 = 75025 is the first term past 16 bits, so the abort lands on r9.
        run(0, 0, 1, 30, 1'b0);
        check("fib30_ovf", 32'(o_ovf), 32'd1);
        check("fib30_last_idx", 32'(o_last_idx), 32'd9);
        check("fib30_r9_wrapped", 32'(env_regs[9]), 32'd9489);
        check("fib30_r10_kept", 32'(env_regs[10]), 32'd55);

        run(1, 0, 0, 0, 1'b0);
        check("cnt0_ovf_cleared", 32'(o_ovf), 32'd0);
        check("cnt0_last_idx_held", 32'(o_last_idx), 32'd9);

        run(1, 100, 7, 5, 1'b1);
        for (int i = 0; i < 5; i++) check("arith_reg", 32'(env_regs[i]), 32'(ari_exp[i]));

        run(2, 3, 999, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("double_reg", 32'(env_regs[i]), 32'(dbl_exp[i]));
        check("double_last_idx", 32'(o_last_idx), 32'd3);

        run(0, 77, 5, 1, 1'b0);
        check("cnt1_r0", 32'(env_regs[0]), 32'd77);
        check("cnt1_r1_kept", 32'(env_regs[1]), 32'd6);
        check("cnt1_last_idx", 32'(o_last_idx), 32'd0);

        run(2, 40000, 0, 2, 1'b0);
        run(1, 16'hFFFF, 1, 4, 1'b0);
        check("seed_carry_ignored", 32'(o_ovf), 32'd0);
        check("seed_carry_r3", 32'(env_regs[3]), 32'd2);
        run(3, 2, 3, 8, 1'b1);
        run(2, 1, 0, 18, 1'b0);

        // Reset in the middle of STEP for term 4.
        build_model(0, 0, 1, 20);
        @(negedge clk);
        mode = 2'd0; seed0 = 16'd0; seed1 = 16'd1; count = 8'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_write", 32'(o_buff_en), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_done", 32'(o_done), 32'd0);
        check("mid_rst_reg_en", 32'(o_reg_en), 32'd0);
        check("mid_rst_buff_en", 32'(o_buff_en), 32'd0);
        check("mid_rst_last_idx", 32'(o_last_idx), 32'd0);
        apply_terms(4);
        prev_last = 0;
        @(negedge clk);
        rst = 1'b0;
        run(0, 0, 1, 10, 1'b1);
        for (int i = 0; i < 10; i++) check("post_rst_fib", 32'(env_regs[i]), 32'(fib_exp[i]));

        for (int r = 0; r < 16; r++) begin
            int md, s0, s1, cnt;
            md  = int'($urandom_range(0, 3));
            s0  = int'($urandom & ((r % 2 == 0) ? 32'h00FF : 32'hFFFF));
            s1  = int'($urandom & ((r % 3 == 0) ? 32'hFFFF : 32'h003F));
            cnt = int'($urandom_range(0, 40));
            run(md, s0, s1, cnt, cnt >= 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
